// File: rtl/clock_ctrl.sv
// Mode/time-set controller: debounced MODE/INC keys, RUN/SET_HOUR/SET_MIN FSM, counter enables and blink.
// Latency: raw key edge to press pulse and mode change 2+DB_CYCLES clk; enables are combinational from state.
// Backpressure: none; every tick, carry and key press is consumed in the cycle it appears.
module clock_ctrl #(
    parameter int DB_CYCLES     = 16,
    parameter int HOLD_CYCLES   = 64,
    parameter int REPEAT_CYCLES = 16,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       sec_carry,
    input  logic       min_carry,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int DW = $clog2(DB_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    keys;
    logic [1:0]    level;
    logic [1:0]    rise;
    logic          inc_press;
    logic          inc_rpt;
    logic          inc_pulse;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] to_cnt;
    logic          blink_q;

    assign keys = {key_inc, key_mode};

    // index 0 = MODE, index 1 = INC; rise is the cycle in which the stable level is about to go 0->1
    for (genvar g = 0; g < 2; g++) begin : g_key
        logic          s1;
        logic          s2;
        logic          lvl;
        logic [DW-1:0] cnt;

        assign level[g] = lvl;
        assign rise[g]  = s2 & ~lvl & (cnt == DW'(DB_CYCLES - 1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                lvl <= 1'b0;
                cnt <= '0;
            end else begin
                s1 <= keys[g];
                s2 <= s1;
                if (s2 != lvl) begin
                    if (cnt == DW'(DB_CYCLES - 1)) begin
                        lvl <= s2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

    // an INC press landing with a MODE press is swallowed so it cannot hit the newly selected field
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_press <= 1'b0;
            inc_rpt   <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            inc_press <= rise[1] & ~rise[0];
            if (!level[1]) begin
                hold_cnt <= '0;
                inc_rpt  <= 1'b0;
            end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                hold_cnt <= HW'(HOLD_CYCLES - REPEAT_CYCLES);
                inc_rpt  <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
                inc_rpt  <= 1'b0;
            end
        end
    end

    assign inc_pulse = inc_press | inc_rpt;

    always_comb begin
        state_nxt = state;
        if (rise[0]) begin
            case (state)
                RUN:      state_nxt = SET_HOUR;
                SET_HOUR: state_nxt = SET_MIN;
                default:  state_nxt = RUN;
            endcase
        end else if (state != RUN && !inc_pulse && to_cnt == TW'(TIMEOUT_TICKS)) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            to_cnt  <= '0;
            blink_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RUN || rise[0] || inc_pulse) begin
                to_cnt <= '0;
            end else if (tick_1hz && to_cnt != TW'(TIMEOUT_TICKS)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (state_nxt != state) begin
                blink_q <= (state_nxt != RUN);
            end else if (state != RUN && tick_1hz) begin
                blink_q <= ~blink_q;
            end
        end
    end

    always_comb begin
        sec_en  = 1'b0;
        min_en  = 1'b0;
        hour_en = 1'b0;
        case (state)
            RUN: begin
                sec_en  = tick_1hz;
                min_en  = sec_carry;
                hour_en = min_carry;
            end
            SET_HOUR: hour_en = inc_pulse;
            SET_MIN:  min_en  = inc_pulse;
            default: ;
        endcase
        if (rst) begin
            sec_en  = 1'b0;
            min_en  = 1'b0;
            hour_en = 1'b0;
        end
    end

    assign mode  = state;
    assign blink = (state != RUN) & (blink_q | inc_pulse);

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with short debounce/repeat/timeout parameters.
// Expected values are hand-derived cycle counts from the raw key edge.
module tb_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       key_mode;
    logic       key_inc;
    logic       sec_carry;
    logic       min_carry;
    logic       sec_en;
    logic       min_en;
    logic       hour_en;
    logic [1:0] mode;
    logic       blink;

    int n_chk  = 0;
    int n_pass = 0;
    int sec_cnt  = 0;
    int min_cnt  = 0;
    int hour_cnt = 0;
    int snap_s;
    int snap_m;
    int snap_h;
    logic [22:0] mask;

    clock_ctrl #(
        .DB_CYCLES    (4),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .TIMEOUT_TICKS(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .sec_carry(sec_carry),
        .min_carry(min_carry),
        .sec_en   (sec_en),
        .min_en   (min_en),
        .hour_en  (hour_en),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sec_en)  sec_cnt++;
        if (min_en)  min_cnt++;
        if (hour_en) hour_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
    endtask

    task automatic press_mode();
        key_mode = 1'b1;
        step(10);
        key_mode = 1'b0;
        step(10);
    endtask

    initial begin
        rst       = 1'b1;
        tick_1hz  = 1'b1;
        key_mode  = 1'b0;
        key_inc   = 1'b0;
        sec_carry = 1'b1;
        min_carry = 1'b1;
        step(2);
        check("rst_sec_en", 32'(sec_en), 0);
        check("rst_min_en", 32'(min_en), 0);
        check("rst_hour_en", 32'(hour_en), 0);
        tick_1hz  = 1'b0;
        sec_carry = 1'b0;
        min_carry = 1'b0;
        rst       = 1'b0;
        step(2);
        check("rst_mode", 32'(mode), 0);
        check("rst_blink", 32'(blink), 0);

        // RUN: three ticks advance seconds only
        snap_s = sec_cnt; snap_m = min_cnt; snap_h = hour_cnt;
        for (int i = 0; i < 3; i++) begin
            tick_pulse();
            step(2);
        end
        check("run_sec_pulses", 32'(sec_cnt - snap_s), 3);
        check("run_min_pulses", 32'(min_cnt - snap_m), 0);
        check("run_hour_pulses", 32'(hour_cnt - snap_h), 0);
        check("run_mode", 32'(mode), 0);
        check("run_blink", 32'(blink), 0);

        // 3-clk glitch on MODE is rejected
        key_mode = 1'b1;
        step(3);
        key_mode = 1'b0;
        step(12);
        check("glitch_mode", 32'(mode), 0);

        // held MODE: transition lands 6 clk after the raw edge
        key_mode = 1'b1;
        step(5);
        check("mode_lat_early", 32'(mode), 0);
        step(1);
        check("mode_lat", 32'(mode), 1);
        check("blink_entry", 32'(blink), 1);
        step(4);
        key_mode = 1'b0;
        step(12);
        check("mode_once", 32'(mode), 1);

        press_mode();
        check("mode_set_min", 32'(mode), 2);

        // SET_MIN: one INC press, with tick and both carries active
        snap_m = min_cnt; snap_h = hour_cnt; snap_s = sec_cnt;
        key_inc = 1'b1;
        step(5);
        tick_1hz  = 1'b1;
        sec_carry = 1'b1;
        min_carry = 1'b1;
        step(1);
        check("setmin_min_en", 32'(min_en), 1);
        check("setmin_sec_en", 32'(sec_en), 0);
        check("setmin_hour_en", 32'(hour_en), 0);
        check("blink_forced", 32'(blink), 1);
        tick_1hz  = 1'b0;
        sec_carry = 1'b0;
        min_carry = 1'b0;
        key_inc   = 1'b0;
        step(1);
        check("blink_toggled", 32'(blink), 0);
        step(12);
        check("setmin_min_pulses", 32'(min_cnt - snap_m), 1);
        check("setmin_other_pulses", 32'((hour_cnt - snap_h) + (sec_cnt - snap_s)), 0);

        // auto-repeat: pulses at offsets 0, 8, 12, 16, 20 from the press
        key_inc = 1'b1;
        step(6);
        for (int k = 0; k < 23; k++) begin
            mask[k] = min_en;
            if (k == 18) key_inc = 1'b0;
            step(1);
        end
        check("repeat_mask", 32'(mask), 32'h0011_1101);
        step(15);

        press_mode();
        check("back_to_run", 32'(mode), 0);
        check("run_blink_again", 32'(blink), 0);

        // timeout with no keys
        press_mode();
        check("to_enter", 32'(mode), 1);
        tick_pulse(); step(3);
        tick_pulse(); step(3);
        tick_pulse();
        check("to_edge", 32'(mode), 1);
        step(1);
        check("to_run", 32'(mode), 0);

        // an INC press after the 2nd tick restarts the timeout
        press_mode();
        snap_h = hour_cnt;
        tick_pulse(); step(3);
        tick_pulse(); step(3);
        key_inc = 1'b1;
        step(6);
        key_inc = 1'b0;
        step(12);
        tick_pulse();
        step(1);
        check("to_inc_hold", 32'(mode), 1);
        check("to_inc_hour", 32'(hour_cnt - snap_h), 1);
        tick_pulse(); step(2);
        tick_pulse(); step(1);
        check("to_after_inc", 32'(mode), 0);

        // MODE and INC debounced together in RUN
        snap_h = hour_cnt;
        key_mode = 1'b1;
        key_inc  = 1'b1;
        step(6);
        check("simul_mode", 32'(mode), 1);
        check("simul_hour_en", 32'(hour_en), 0);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        step(15);
        check("simul_hour_pulses", 32'(hour_cnt - snap_h), 0);

        // async reset in the middle of SET_MIN
        press_mode();
        check("pre_rst_mode", 32'(mode), 2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_mode", 32'(mode), 0);
        check("arst_blink", 32'(blink), 0);
        tick_1hz  = 1'b1;
        sec_carry = 1'b1;
        min_carry = 1'b1;
        #1;
        check("arst_enables", 32'({sec_en, min_en, hour_en}), 0);
        tick_1hz  = 1'b0;
        sec_carry = 1'b0;
        min_carry = 1'b0;
        step(1);
        rst = 1'b0;
        step(2);
        check("post_rst_mode", 32'(mode), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Mode and time-set controller for the digital clock datapath. It drives the enable inputs of the seconds and minutes mod-60 counters and the hours counter. It debounces two push-buttons (MODE, INC) and runs a RUN / SET_HOUR / SET_MIN state machine. In RUN it chains counter carries; in the set modes it routes INC presses, including auto-repeat, to the selected counter and provides a blink flag for the display.

Parameters:
DB_CYCLES, 16, clk cycles a raw key level must stay stable before it is accepted (>=2)
HOLD_CYCLES, 64, clk cycles INC must be held before the first auto-repeat pulse
REPEAT_CYCLES, 16, clk cycles between subsequent auto-repeat pulses
TIMEOUT_TICKS, 10, tick_1hz pulses with no accepted key press before a SET state returns to RUN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tick_1hz  in  1  one-clk-wide pulse, once per second
key_mode  in  1  raw MODE button, active-high, asynchronous
key_inc  in  1  raw INC button, active-high, asynchronous
sec_carry  in  1  seconds counter next_enable (already gated by its enable)
min_carry  in  1  minutes counter next_enable (already gated by its enable)
sec_en  out  1  enable to seconds counter
min_en  out  1  enable to minutes counter
hour_en  out  1  enable to hours counter
mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN (3 never driven)
blink  out  1  display blink flag for the selected field

Behaviour:
- Reset (async, rst=1): state=RUN, mode=0, blink=0, all debounce/repeat/timeout counters=0, stable key levels=0.
- While rst=1: sec_en, min_en and hour_en are forced to 0.
- Key path, per key:
  - 2-FF synchronizer, then a debounce counter.
  - If the synced level differs from the stable level, the counter increments; otherwise it clears.
  - When the counter reaches DB_CYCLES-1, the stable level takes the synced level and the counter clears.
  - A press pulse is one clk wide and is registered on the stable 0->1 edge.
  - Latency from a clean raw edge to the press pulse is 2+DB_CYCLES clk.
- Auto-repeat (INC only):
  - While the INC stable level is 1, a hold counter runs.
  - First repeat pulse occurs HOLD_CYCLES clk after the press pulse, then one every REPEAT_CYCLES.
  - Counter clears when the stable level goes 0.
  - inc_pulse = press pulse OR repeat pulse.
- FSM (advances on a MODE press): RUN -> SET_HOUR -> SET_MIN -> RUN.
- Timeout:
  - In SET_HOUR and SET_MIN, the timeout counter increments on each tick_1hz.
  - It clears on any accepted press (MODE or inc_pulse) and on entry to a SET state.
  - When TIMEOUT_TICKS ticks are counted, state returns to RUN the next clk.
  - If a press and the final tick coincide, the press wins and the counter clears.
- Enables (combinational from the state register and inputs):
  - RUN: sec_en=tick_1hz; min_en=sec_carry; hour_en=min_carry.
  - SET_HOUR: sec_en=0; min_en=0; hour_en=inc_pulse.
  - SET_MIN: sec_en=0; min_en=inc_pulse; hour_en=0. Minutes wrapping from 59 to 00 do not advance hours.
- Simultaneous MODE and INC press in the same clk: the MODE transition occurs and that inc_pulse is dropped (no enable).
- blink:
  - 0 in RUN.
  - Set to 1 on entry to a SET state, toggles on each tick_1hz while in a SET state.
  - Forced to 1 for the cycle of any inc_pulse, so the field is visible while adjusting.
- mode output is registered, equal to the state encoding.
- Key presses are ignored during reset. After rst falls, a key already held is reported as a press once debounced.

Test Plan:
- Reset, then 3 tick_1hz pulses with sec_carry=0 -> sec_en pulses exactly 3 times, min_en=hour_en=0, mode=0, blink=0.
- DB_CYCLES=4, key_mode glitch high for 3 clk -> no transition. Held high for 10 clk -> mode 0->1 exactly once, 6 clk after the raw edge.
- In SET_MIN, one INC press -> min_en high for exactly 1 clk. With sec_carry=1 and tick_1hz=1 asserted, sec_en=0 and hour_en=0.
- HOLD_CYCLES=8, REPEAT_CYCLES=4, INC held 20 clk after debounce -> min_en pulses at offsets 0, 8, 12, 16, 20 (5 pulses).
- TIMEOUT_TICKS=3, enter SET_HOUR, no keys, 3 ticks -> mode returns to 0 one clk after the 3rd tick. Repeat with an INC press after the 2nd tick -> still in SET_HOUR after the 3rd tick.
- MODE and INC debounced in the same clk while in RUN -> mode=1 and no hour_en pulse. Assert rst mid-SET_MIN -> mode=0, blink=0, enables 0 immediately (async).
